// File: rtl/iddmm_pkg.sv
// Shared types and defaults for the IDDMM scheduler and word datapath.
package iddmm_pkg;

   localparam int unsigned IDDMM_K = 128;
   localparam int unsigned IDDMM_N = 32;

   // q becomes valid this many cycles after a round's last word reaches iddmm_cal
   localparam int unsigned IDDMM_Q_LATENCY = 17;

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} sched_state_t;

endpackage

// File: rtl/iddmm_sched.sv
// Operand sequencer for the IDDMM loop nest: walks i over y words and j = 0..N,
// reads the x/y/p/a RAMs and issues one aligned operand word per cycle to iddmm_cal.
module iddmm_sched
   import iddmm_pkg::sched_state_t;
   import iddmm_pkg::IDLE;
   import iddmm_pkg::RUN;
   import iddmm_pkg::DONE;
#(
   parameter int unsigned  K         = iddmm_pkg::IDDMM_K,
   parameter int unsigned  N         = iddmm_pkg::IDDMM_N,
   parameter int unsigned  GAP       = 20,
   parameter bit           CHECK_GAP = 1'b1,
   localparam int unsigned ADDR_W    = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [K-1:0]      p1_in,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] x_raddr,
   input  logic [K-1:0]      x_rdata,
   output logic [ADDR_W-1:0] y_raddr,
   input  logic [K-1:0]      y_rdata,
   output logic [ADDR_W-1:0] p_raddr,
   input  logic [K-1:0]      p_rdata,
   output logic [ADDR_W-1:0] a_raddr,
   input  logic [K-1:0]      a_rdata,
   output logic              o_vld,
   output logic [ADDR_W-1:0] o_i_cnt,
   output logic [ADDR_W:0]   o_j_cnt,
   output logic [K-1:0]      o_x,
   output logic [K-1:0]      o_y,
   output logic [K-1:0]      o_p,
   output logic [K-1:0]      o_a,
   output logic [K-1:0]      o_p1
);

   localparam int unsigned     GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [ADDR_W:0]   J_LAST = (ADDR_W + 1)'(N);
   localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N - 1);
   localparam logic [GAP_W-1:0]  G_LAST = GAP_W'(GAP - 1);

   if (GAP < 1) begin : g_gap_zero
      $error("iddmm_sched: GAP must be at least 1");
   end
   if (CHECK_GAP && (GAP < iddmm_pkg::IDDMM_Q_LATENCY)) begin : g_gap_short
      $error("iddmm_sched: GAP shorter than the downstream q latency");
   end

   sched_state_t      state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [ADDR_W:0]   j_q, j_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [K-1:0]      p1_q, p1_d;
   logic              busy_q, done_q;
   logic              vld_q;
   logic [ADDR_W-1:0] i_cnt_q;
   logic [ADDR_W:0]   j_cnt_q;
   logic [K-1:0]      x_q, y_q, p_q, a_q;
   logic              run;
   logic              carry_slot;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      gap_d   = gap_q;
      p1_d    = p1_q;
      unique case (state_q)
         IDLE: begin
            // busy_q is still high on the done cycle, so a start there is dropped
            if (start && !busy_q) begin
               state_d = RUN;
               i_d     = '0;
               j_d     = '0;
               p1_d    = p1_in;
            end
         end
         RUN: begin
            if (j_q == J_LAST) begin
               state_d = iddmm_pkg::GAP;
               gap_d   = '0;
            end else begin
               j_d = j_q + (ADDR_W + 1)'(1);
            end
         end
         iddmm_pkg::GAP: begin
            if (gap_q == G_LAST) begin
               if (i_q != I_LAST) begin
                  state_d = RUN;
                  i_d     = i_q + ADDR_W'(1);
                  j_d     = '0;
               end else begin
                  state_d = DONE;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Addresses look one cycle ahead (next-state counters) so the RAM output lines up
   // with the current j/i and can be captured straight into the output stage.
   assign x_raddr = rst ? '0 : j_d[ADDR_W-1:0];
   assign p_raddr = rst ? '0 : j_d[ADDR_W-1:0];
   assign a_raddr = rst ? '0 : j_d[ADDR_W-1:0];
   assign y_raddr = rst ? '0 : i_d;

   assign run        = (state_q == RUN);
   assign carry_slot = (j_q == J_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         gap_q   <= '0;
         p1_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
         i_cnt_q <= '0;
         j_cnt_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         p_q     <= '0;
         a_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         gap_q   <= gap_d;
         p1_q    <= p1_d;
         busy_q  <= (state_d != IDLE) || (state_q == DONE);
         done_q  <= (state_q == DONE);
         vld_q   <= run;
         i_cnt_q <= run ? i_q : '0;
         j_cnt_q <= run ? j_q : '0;
         x_q     <= (run && !carry_slot) ? x_rdata : '0;
         y_q     <= run ? y_rdata : '0;
         p_q     <= (run && !carry_slot) ? p_rdata : '0;
         // the accumulator starts cleared, so round 0 never uses the a RAM
         a_q     <= (run && !carry_slot && (i_q != '0)) ? a_rdata : '0;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign o_vld   = vld_q;
   assign o_i_cnt = i_cnt_q;
   assign o_j_cnt = j_cnt_q;
   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_p     = p_q;
   assign o_a     = a_q;
   assign o_p1    = p1_q;

endmodule

// File: tb/tb_iddmm_sched.sv
// Self-checking bench for iddmm_sched with small operands and behavioural 1-cycle RAMs.
module tb_iddmm_sched;

   localparam int unsigned K  = 16;
   localparam int unsigned N  = 4;
   localparam int unsigned GAP = 3;
   localparam int unsigned AW = 2;
   localparam int OP_CYCLES = N * (N + 1 + GAP) + 2;

   typedef struct packed {
      logic [AW-1:0] i;
      logic [AW:0]   j;
      logic [K-1:0]  x;
      logic [K-1:0]  y;
      logic [K-1:0]  p;
      logic [K-1:0]  a;
      logic [K-1:0]  p1;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [K-1:0]  p1_in;
   logic          busy, done;
   logic [AW-1:0] x_raddr, y_raddr, p_raddr, a_raddr;
   logic [K-1:0]  x_rdata, y_rdata, p_rdata, a_rdata;
   logic          o_vld;
   logic [AW-1:0] o_i_cnt;
   logic [AW:0]   o_j_cnt;
   logic [K-1:0]  o_x, o_y, o_p, o_a, o_p1;

   word_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;

   iddmm_sched #(
      .K         (K),
      .N         (N),
      .GAP       (GAP),
      .CHECK_GAP (1'b0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .p1_in   (p1_in),
      .busy    (busy),
      .done    (done),
      .x_raddr (x_raddr),
      .x_rdata (x_rdata),
      .y_raddr (y_raddr),
      .y_rdata (y_rdata),
      .p_raddr (p_raddr),
      .p_rdata (p_rdata),
      .a_raddr (a_raddr),
      .a_rdata (a_rdata),
      .o_vld   (o_vld),
      .o_i_cnt (o_i_cnt),
      .o_j_cnt (o_j_cnt),
      .o_x     (o_x),
      .o_y     (o_y),
      .o_p     (o_p),
      .o_a     (o_a),
      .o_p1    (o_p1)
   );

   always #5 clk = ~clk;

   // Behavioural RAMs: x[k]=0x10+k, y[k]=0x20+k, p[k]=0x30+k, a[k]=0x40+k
   always @(posedge clk) begin
      x_rdata <= 16'h0010 + {14'd0, x_raddr};
      y_rdata <= 16'h0020 + {14'd0, y_raddr};
      p_rdata <= 16'h0030 + {14'd0, p_raddr};
      a_rdata <= 16'h0040 + {14'd0, a_raddr};
   end

   task automatic test_reset();
      word_t got;
      rst   = 1'b1;
      start = 1'b0;
      p1_in = '0;
      repeat (3) @(negedge clk);
      got = {o_i_cnt, o_j_cnt, o_x, o_y, o_p, o_a, o_p1};
      n_cmp++;
      if ({busy, done, o_vld} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ctrl: busy/done/vld=%b want 000", {busy, done, o_vld});
      end
      n_cmp++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", got);
      end
      n_cmp++;
      if ({x_raddr, y_raddr, p_raddr, a_raddr} !== '0) begin
         n_err++;
         $display("FAIL reset_addr: got %h want 0", {x_raddr, y_raddr, p_raddr, a_raddr});
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, o_vld} !== 2'b00) begin
         n_err++;
         $display("FAIL idle_after_reset: busy/vld=%b want 00", {busy, o_vld});
      end
   endtask

   task automatic test_full_op(input logic [K-1:0] p1, input bit poke);
      word_t       e;
      word_t       got;
      int          cyc;
      int          nvld;
      int          idle_run;
      int          first_vld;
      int          want_gap;
      bit          seen_done;
      logic [AW:0] prev_j;
      sb.delete();
      for (int i = 0; i < int'(N); i++) begin
         for (int j = 0; j <= int'(N); j++) begin
            e.i  = AW'(i);
            e.j  = (AW + 1)'(j);
            e.x  = (j == int'(N)) ? '0 : K'(32'h10 + j);
            e.y  = K'(32'h20 + i);
            e.p  = (j == int'(N)) ? '0 : K'(32'h30 + j);
            e.a  = (j == int'(N) || i == 0) ? '0 : K'(32'h40 + j);
            e.p1 = p1;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      start = 1'b1;
      p1_in = p1;
      @(negedge clk);
      start     = 1'b0;
      p1_in     = K'(16'hdead);
      cyc       = 1;
      nvld      = 0;
      idle_run  = 0;
      first_vld = 0;
      seen_done = 1'b0;
      prev_j    = '0;
      while (!seen_done && cyc <= OP_CYCLES + 10) begin
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_during_op: cycle %0d busy=%b want 1", cyc, busy);
         end
         if (o_vld === 1'b1) begin
            got = {o_i_cnt, o_j_cnt, o_x, o_y, o_p, o_a, o_p1};
            if (nvld == 0) begin
               first_vld = cyc;
            end else begin
               want_gap = (prev_j == (AW + 1)'(N)) ? int'(GAP) : 0;
               n_cmp++;
               if (idle_run != want_gap) begin
                  n_err++;
                  $display("FAIL idle_gap: cycle %0d saw %0d idle cycles want %0d",
                           cyc, idle_run, want_gap);
               end
            end
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL extra_word: cycle %0d got %h want no word", cyc, got);
            end else begin
               e = sb.pop_front();
               if (got !== e) begin
                  n_err++;
                  $display("FAIL word: cycle %0d got %h want %h", cyc, got, e);
               end
            end
            prev_j   = o_j_cnt;
            nvld++;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (done === 1'b1) begin
            seen_done = 1'b1;
         end else begin
            start = poke && (cyc % 5 == 0);
            @(negedge clk);
            cyc++;
         end
      end
      n_cmp++;
      if (!seen_done || cyc != OP_CYCLES) begin
         n_err++;
         $display("FAIL done_latency: done seen=%0d at cycle %0d want cycle %0d",
                  seen_done, cyc, OP_CYCLES);
      end
      n_cmp++;
      if (first_vld != 2) begin
         n_err++;
         $display("FAIL first_valid: cycle %0d want 2", first_vld);
      end
      n_cmp++;
      if (nvld != int'(N * (N + 1))) begin
         n_err++;
         $display("FAIL valid_count: got %0d want %0d", nvld, N * (N + 1));
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL missing_words: %0d words never issued want 0", sb.size());
      end
      // a start on the done cycle must be dropped
      start = poke;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if ({busy, done, o_vld} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_done: +%0d busy/done/vld=%b want 000",
                     k + 1, {busy, done, o_vld});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_busy_start();
      test_full_op(K'(16'h1234), 1'b1);
   endtask

   task automatic test_reset_mid();
      int    cyc;
      word_t got;
      @(negedge clk);
      start = 1'b1;
      p1_in = K'(16'h5a5a);
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!(o_vld === 1'b1 && o_i_cnt === AW'(2) && o_j_cnt === 3'd1) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc >= 100) begin
         n_err++;
         $display("FAIL reach_round2: waited %0d cycles want < 100", cyc);
      end
      rst = 1'b1;
      @(negedge clk);
      got = {o_i_cnt, o_j_cnt, o_x, o_y, o_p, o_a, o_p1};
      n_cmp++;
      if ({busy, done, o_vld} !== 3'b000) begin
         n_err++;
         $display("FAIL midreset_ctrl: busy/done/vld=%b want 000", {busy, done, o_vld});
      end
      n_cmp++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL midreset_data: got %h want 0", got);
      end
      n_cmp++;
      if ({x_raddr, y_raddr, p_raddr, a_raddr} !== '0) begin
         n_err++;
         $display("FAIL midreset_addr: got %h want 0", {x_raddr, y_raddr, p_raddr, a_raddr});
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, o_vld} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after_midreset: busy/vld=%b want 00", {busy, o_vld});
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      p1_in = '0;
      test_reset();
      test_full_op(K'(16'hBEEF), 1'b0);
      test_busy_start();
      test_reset_mid();
      test_full_op(K'(16'hC0DE), 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
